lbp_code_collector: RTL and testbench
=====================================

Name: lbp_code_collector

Overview:
Downstream consumer of the pixel-readout sequencer's serial result stream (start/bit/strobe/done), clocked on wb_clk_i.
- Deserialises comparator bits into CODE_W-bit local-binary-pattern codes, one bit per photodiode.
- Buffers codes in a small FIFO.
- Exposes codes, status and an interrupt to the management core through a Wishbone slave.

Parameters:
CODE_W, 12, bits per code (one per photodiode pixel), 1..16
FIFO_DEPTH, 16, code FIFO entries, power of 2, >=2
BASE_ADDR, 32'h3000_0100, Wishbone base; registers at +0x0, +0x4, +0x8

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  frame-start pulse from sequencer, synchronous to wb_clk_i
bit_valid_i  in  1  one-cycle strobe, bit_i valid
bit_i  in  1  comparator result bit, MSB (pixel 1) first
done_i  in  1  frame-end pulse from sequencer
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects (ignored, full-word access)
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
irq_o  out  1  level interrupt = frame_done & irq_en

Behaviour:
- Reset (async assert, sync deassert inside): state IDLE; bit count 0; shift reg 0; FIFO empty; all sticky flags 0; irq_en 0; wbs_ack_o 0; wbs_dat_o 0; irq_o 0.
- FSM states:
  - IDLE: start_i -> SHIFT, count cleared. bit_valid_i and done_i are ignored.
  - SHIFT: each bit_valid_i shifts bit_i in at LSB (first bit ends in MSB) and increments count.
    - When count reaches CODE_W, the code is pushed to the FIFO in the same cycle and count returns to 0.
    - done_i: if count != 0, set short_frame and discard the partial code. Set frame_done; -> IDLE.
    - start_i: if count != 0, set short_frame; clear count; stay in SHIFT.
  - Simultaneous bit_valid_i + done_i: the bit is processed first, so a completing bit is pushed and no short_frame is set. Then done_i is applied.
  - Simultaneous start_i + done_i in SHIFT: done_i wins (-> IDLE); start_i is ignored.
- FIFO behaviour:
  - Push while full: code dropped; set overflow sticky.
  - Pop while empty: no effect.
  - Push and pop in the same cycle when full: both occur; level unchanged; no overflow.
  - Level ranges 0..FIFO_DEPTH.
- Registers (word address = wbs_adr_i[3:2]; access requires wbs_adr_i[31:4] == BASE_ADDR[31:4]):
  - +0x0 STATUS (R):
    - [7:0] level
    - [8] empty
    - [9] full
    - [10] frame_done
    - [11] overflow
    - [12] short_frame
    - [13] busy (state == SHIFT)
  - +0x0 STATUS (W): write-1-to-clear bits [12:10].
  - +0x4 DATA (R): [CODE_W-1:0] head code, zero-extended; the read pops one entry. When empty, returns 0 and does not pop. Writes are ignored.
  - +0x8 CTRL (R/W):
    - [0] irq_en
    - [1] flush: write 1 empties the FIFO; self-clearing, reads 0.
- Wishbone timing:
  - wbs_ack_o asserts the cycle after cyc&stb&!ack and lasts exactly one cycle, so back-to-back accesses take 2 cycles each.
  - Read data is registered and valid with ack.
  - The pop/clear side effect takes place in the ack cycle, exactly once per access.
  - Unmapped addresses inside the window read 0 and are still acked.
- A sticky-set event and a W1C in the same cycle: the set wins.
- A FIFO push and a flush in the same cycle: flush wins; the FIFO ends empty.

Optional Feature:
FRAME_TAG_EN:
- Defined: an 8-bit frame counter (reset 0) increments on every accepted done_i and wraps 255 -> 0. Each pushed code carries the current counter, stored alongside the code and returned in DATA[23:16]. STATUS[31:24] reads the live counter.
- Undefined: no counter or extra storage; DATA[23:16] and STATUS[31:24] read 0.

Test Plan:
1. Reset, start_i, 12 bits 1,0,1,0,0,0,0,0,0,0,1,1, done_i -> STATUS level=1, frame_done=1. DATA read=0x00000A03, after which level=0. irq_o=1 only after CTRL=0x1.
2. 17 full frames with no reads -> level=16, full=1, overflow=1. The first 16 codes read back in order.
3. start_i, 5 bits, done_i -> short_frame=1, level=0. W1C 0x1C00 to STATUS -> STATUS[12:10]=0.
4. 12th bit_valid_i in the same cycle as done_i -> code pushed (level=1), short_frame=0.
5. DATA read when empty -> returns 0, ack after 1 cycle, level stays 0. Pop in the same cycle as a push at full -> level stays 16, overflow=0.
6. FRAME_TAG_EN defined, 3 frames -> DATA[23:16] reads 0, 1, 2. Assert wb_rst_i mid-SHIFT -> all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/lbp_code_collector.sv
// ============================================================================
// lbp_code_collector: deserialises sequencer comparator bits into LBP codes,
// buffers them in a FIFO and serves them over a Wishbone slave.
// Optional feature macro: FRAME_TAG_EN (8-bit frame tag per code).
// Revision: 1.0
// ============================================================================
`default_nettype none

module lbp_code_collector #(
  parameter int          CODE_W     = 12,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        bit_valid_i,
  input  logic        bit_i,
  input  logic        done_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int             AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]  c_ptr_one  = AW'(1);
  localparam logic [AW:0]    c_lvl_one  = (AW+1)'(1);
  localparam logic [AW:0]    c_lvl_full = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]     c_last_bit = 5'(CODE_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_pipe;
  logic       w_rst;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_rst_pipe <= 2'b11;
    else          r_rst_pipe <= {r_rst_pipe[0], 1'b0};
  end

  assign w_rst = r_rst_pipe[1];

  state_t              r_state, w_state_nxt;
  logic [4:0]          r_count, w_count_nxt;
  logic [CODE_W-1:0]   r_shift, w_shift_nxt;
  logic [CODE_W:0]     w_shift_ext;
  logic                w_push, w_short_set, w_done_acc;

  logic [CODE_W-1:0]   r_code_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [AW:0]         r_level;
  logic                w_empty, w_full, w_pop, w_push_ok, w_flush, w_overflow_set;

  logic                r_frame_done, r_overflow, r_short_frame, r_irq_en;
  logic                r_ack;
  logic [31:0]         r_dat;

  logic                w_in_window, w_req, w_w1c, w_ctrl_wr;
  logic [1:0]          w_word;
  logic [31:0]         w_status, w_data_word, w_rdata, w_level32;
  logic [7:0]          w_head_tag, w_live_tag;
  logic [CODE_W-1:0]   w_head_code;
  logic                w_unused;

  assign w_unused = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:13], wbs_dat_i[9:2]};

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_shift_ext = {r_shift, bit_i};

  // The bit is applied before done/start so a completing bit still pushes.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_short_set = 1'b0;
    w_done_acc  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_SHIFT;
          w_count_nxt = '0;
        end
      end
      S_SHIFT: begin
        if (bit_valid_i) begin
          w_shift_nxt = w_shift_ext[CODE_W-1:0];
          if (r_count == c_last_bit) begin
            w_push      = 1'b1;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + 5'd1;
          end
        end
        if (done_i) begin
          w_short_set = (w_count_nxt != '0);
          w_done_acc  = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (start_i) begin
          w_short_set = (w_count_nxt != '0);
          w_count_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wishbone decode
  // ---------------------------------------------------------------------------
  assign w_in_window = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_req       = wbs_cyc_i & wbs_stb_i & ~r_ack & w_in_window;
  assign w_word      = wbs_adr_i[3:2];
  assign w_w1c       = w_req & wbs_we_i & (w_word == 2'd0);
  assign w_ctrl_wr   = w_req & wbs_we_i & (w_word == 2'd2);
  assign w_flush     = w_ctrl_wr & wbs_dat_i[1];

  assign w_empty        = (r_level == '0);
  assign w_full         = (r_level == c_lvl_full);
  assign w_pop          = w_req & ~wbs_we_i & (w_word == 2'd1) & ~w_empty;
  assign w_push_ok      = w_push & (~w_full | w_pop) & ~w_flush;
  assign w_overflow_set = w_push & w_full & ~w_pop & ~w_flush;

  assign w_head_code = r_code_mem[r_rd_ptr];
  assign w_level32   = 32'(r_level);

`ifdef FRAME_TAG_EN
  logic [7:0] r_frame_tag;
  logic [7:0] r_tag_mem [FIFO_DEPTH];

  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst)           r_frame_tag <= 8'h00;
    else if (w_done_acc) r_frame_tag <= r_frame_tag + 8'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_tag_mem[r_wr_ptr] <= r_frame_tag;
  end

  assign w_head_tag = r_tag_mem[r_rd_ptr];
  assign w_live_tag = r_frame_tag;
`else
  assign w_head_tag = 8'h00;
  assign w_live_tag = 8'h00;
`endif

  always_comb begin
    w_status        = '0;
    w_status[7:0]   = w_level32[7:0];
    w_status[8]     = w_empty;
    w_status[9]     = w_full;
    w_status[10]    = r_frame_done;
    w_status[11]    = r_overflow;
    w_status[12]    = r_short_frame;
    w_status[13]    = (r_state == S_SHIFT);
    w_status[31:24] = w_live_tag;
  end

  assign w_data_word = w_empty ? 32'h0 : {8'h00, w_head_tag, 16'(w_head_code)};

  always_comb begin
    w_rdata = '0;
    if (w_req && !wbs_we_i) begin
      case (w_word)
        2'd0:    w_rdata = w_status;
        2'd1:    w_rdata = w_data_word;
        2'd2:    w_rdata = {31'h0, r_irq_en};
        default: w_rdata = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath, FIFO pointers, sticky flags and bus registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (w_push_ok) r_code_mem[r_wr_ptr] <= w_shift_ext[CODE_W-1:0];
  end

  always_ff @(posedge wb_clk_i or posedge w_rst) begin
    if (w_rst) begin
      r_count       <= '0;
      r_shift       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_frame_done  <= 1'b0;
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
      r_irq_en      <= 1'b0;
      r_ack         <= 1'b0;
      r_dat         <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_ack   <= w_req;
      r_dat   <= w_rdata;

      // A set event in the same cycle as its W1C leaves the flag set.
      r_frame_done  <= w_done_acc     | (r_frame_done  & ~(w_w1c & wbs_dat_i[10]));
      r_overflow    <= w_overflow_set | (r_overflow    & ~(w_w1c & wbs_dat_i[11]));
      r_short_frame <= w_short_set    | (r_short_frame & ~(w_w1c & wbs_dat_i[12]));

      if (w_ctrl_wr) r_irq_en <= wbs_dat_i[0];

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_one;
        case ({w_push_ok, w_pop})
          2'b10:   r_level <= r_level + c_lvl_one;
          2'b01:   r_level <= r_level - c_lvl_one;
          default: r_level <= r_level;
        endcase
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_frame_done & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_lbp_code_collector.sv
// Directed bench for lbp_code_collector: hand-computed codes, FIFO levels,
// sticky flags and Wishbone timing.
`default_nettype none

module tb_lbp_code_collector;

  localparam logic [31:0] A_STATUS = 32'h3000_0100;
  localparam logic [31:0] A_DATA   = 32'h3000_0104;
  localparam logic [31:0] A_CTRL   = 32'h3000_0108;
  localparam logic [31:0] A_HOLE   = 32'h3000_010C;
  localparam logic [31:0] M_STAT   = 32'h00FF_FFFF;

  logic        clk, rst, start, bv, b, done, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack, irq;
  logic [31:0] rdat;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic [11:0] code;

  lbp_code_collector dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start),
    .bit_valid_i (bv),
    .bit_i       (b),
    .done_i      (done),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .irq_o       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; n = 0;
    do begin tick(); n++; end while (ack !== 1'b1 && n < 8);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
    chk("wb_read_ack_latency", 32'(n), 32'd1);
    tick();
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; n = 0;
    do begin tick(); n++; end while (ack !== 1'b1 && n < 8);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("wb_write_ack_latency", 32'(n), 32'd1);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic send_bit(input logic v);
    bv = 1'b1; b = v; tick(); bv = 1'b0; b = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] c);
    pulse_start();
    for (int j = 11; j >= 0; j--) send_bit(c[j]);
    pulse_done();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bv = 1'b0; b = 1'b0; done = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; wdat = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Reset state and first frame
    chk("reset_ack", {31'h0, ack}, 32'h0);
    chk("reset_dat", rdat, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    wb_read(A_STATUS, rd);     chk("reset_status", rd, 32'h0000_0100);
    send_frame(12'hA03);
    wb_read(A_STATUS, rd);     chk("t1_status", rd & M_STAT, 32'h0000_0401);
    chk("t1_irq_disabled", {31'h0, irq}, 32'h0);
    wb_read(A_DATA, rd);       chk("t1_data", rd & 32'h0000_FFFF, 32'h0000_0A03);
    wb_read(A_STATUS, rd);     chk("t1_status_popped", rd & M_STAT, 32'h0000_0500);
    wb_write(A_CTRL, 32'h1);
    chk("t1_irq_enabled", {31'h0, irq}, 32'h1);
    wb_read(A_CTRL, rd);       chk("t1_ctrl", rd, 32'h1);
    wb_write(A_STATUS, 32'h1C00);
    chk("t1_irq_cleared", {31'h0, irq}, 32'h0);

    // 17 frames, no reads: overflow, then in-order readback
    for (int i = 0; i <= 16; i++) send_frame(12'(12'h100 + i));
    wb_read(A_STATUS, rd);     chk("t2_status_full", rd & M_STAT, 32'h0000_0E10);
    for (int i = 0; i < 16; i++) begin
      wb_read(A_DATA, rd);
      chk("t2_data_order", rd & 32'h0000_FFFF, 32'(12'h100 + i));
    end
    wb_read(A_STATUS, rd);     chk("t2_status_drained", rd & M_STAT, 32'h0000_0D00);
    wb_write(A_STATUS, 32'h1C00);

    // Short frame and W1C
    pulse_start();
    for (int j = 0; j < 5; j++) send_bit(1'b1);
    pulse_done();
    wb_read(A_STATUS, rd);     chk("t3_short", rd & M_STAT, 32'h0000_1500);
    wb_write(A_STATUS, 32'h1C00);
    wb_read(A_STATUS, rd);     chk("t3_w1c", rd & M_STAT, 32'h0000_0100);

    // Completing bit coincides with done
    code = 12'h5A5;
    pulse_start();
    for (int j = 11; j >= 1; j--) send_bit(code[j]);
    bv = 1'b1; b = code[0]; done = 1'b1; tick(); bv = 1'b0; b = 1'b0; done = 1'b0;
    wb_read(A_STATUS, rd);     chk("t4_status", rd & M_STAT, 32'h0000_0401);
    wb_read(A_DATA, rd);       chk("t4_data", rd & 32'h0000_FFFF, 32'h0000_05A5);
    wb_write(A_STATUS, 32'h1C00);

    // Restart mid-frame flags short but the following full code is kept
    pulse_start();
    for (int j = 0; j < 3; j++) send_bit(1'b0);
    send_frame(12'h0F0);
    wb_read(A_STATUS, rd);     chk("t4_restart_status", rd & M_STAT, 32'h0000_1401);
    wb_read(A_DATA, rd);       chk("t4_restart_data", rd & 32'h0000_FFFF, 32'h0000_00F0);
    wb_write(A_STATUS, 32'h1C00);

    // start and done together in SHIFT: done wins, no short frame
    pulse_start();
    start = 1'b1; done = 1'b1; tick(); start = 1'b0; done = 1'b0;
    wb_read(A_STATUS, rd);     chk("t4_start_done", rd & M_STAT, 32'h0000_0500);
    wb_write(A_STATUS, 32'h1C00);

    // Empty read, then pop at full concurrent with push
    wb_read(A_DATA, rd);       chk("t5_empty_data", rd, 32'h0);
    wb_read(A_STATUS, rd);     chk("t5_empty_status", rd & M_STAT, 32'h0000_0100);
    for (int i = 0; i < 16; i++) send_frame(12'(12'h200 + i));
    wb_read(A_STATUS, rd);     chk("t5_full", rd & M_STAT, 32'h0000_0610);
    code = 12'h2FF;
    pulse_start();
    for (int j = 11; j >= 1; j--) send_bit(code[j]);
    bv = 1'b1; b = code[0]; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DATA;
    tick();
    chk("t5_pushpop_ack", {31'h0, ack}, 32'h1);
    chk("t5_pushpop_data", rdat & 32'h0000_FFFF, 32'h0000_0200);
    bv = 1'b0; b = 1'b0; cyc = 1'b0; stb = 1'b0;
    tick();
    chk("t5_ack_single", {31'h0, ack}, 32'h0);
    pulse_done();
    wb_read(A_STATUS, rd);     chk("t5_pushpop_status", rd & M_STAT, 32'h0000_0610);
    for (int i = 1; i < 16; i++) begin
      wb_read(A_DATA, rd);
      chk("t5_data_order", rd & 32'h0000_FFFF, 32'(12'h200 + i));
    end
    wb_read(A_DATA, rd);       chk("t5_data_last", rd & 32'h0000_FFFF, 32'h0000_02FF);

    // Flush, CTRL readback, unmapped word
    send_frame(12'h011);
    send_frame(12'h022);
    wb_write(A_CTRL, 32'h2);
    wb_read(A_STATUS, rd);     chk("flush_status", rd & M_STAT, 32'h0000_0500);
    wb_read(A_CTRL, rd);       chk("flush_ctrl", rd, 32'h0);
    wb_read(A_HOLE, rd);       chk("unmapped_read", rd, 32'h0);

    // Reset asserted mid-SHIFT
    send_frame(12'h123);
    wb_write(A_CTRL, 32'h1);
    chk("t6_irq_before_reset", {31'h0, irq}, 32'h1);
    pulse_start();
    for (int j = 0; j < 3; j++) send_bit(1'b1);
    wb_read(A_STATUS, rd);     chk("t6_busy", rd & M_STAT, 32'h0000_2401);
    rst = 1'b1;
    #1;
    chk("t6_rst_irq", {31'h0, irq}, 32'h0);
    chk("t6_rst_ack", {31'h0, ack}, 32'h0);
    chk("t6_rst_dat", rdat, 32'h0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    wb_read(A_STATUS, rd);     chk("t6_status_after_reset", rd, 32'h0000_0100);
    wb_read(A_CTRL, rd);       chk("t6_ctrl_after_reset", rd, 32'h0);

    // Frame tags
    send_frame(12'h001);
    send_frame(12'h002);
    send_frame(12'h003);
    wb_read(A_STATUS, rd);
`ifdef FRAME_TAG_EN
    chk("t6_tag_status", rd, 32'h0300_0403);
`else
    chk("t6_tag_status", rd, 32'h0000_0403);
`endif
    for (int i = 0; i < 3; i++) begin
      wb_read(A_DATA, rd);
`ifdef FRAME_TAG_EN
      chk("t6_tag_data", rd, (32'(i) << 16) | 32'(i + 1));
`else
      chk("t6_tag_data", rd, 32'(i + 1));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
